// File: rtl/bsg_chip_period_meter.sv
// bsg_chip_period_meter: measures the average period, in clk_i cycles, of one
// of num_chan_p asynchronous signals over 2^lg_periods_p periods, with a
// no-signal timeout, saturation reporting and a valid/ready result handshake.
// Optional per-period min/max tracking: define BSG_CHIP_PERIOD_METER_MINMAX_EN.
module bsg_chip_period_meter #(
    parameter int unsigned num_chan_p    = 4,
    parameter int unsigned count_width_p = 8,
    parameter int unsigned lg_periods_p  = 2,
    parameter int unsigned sync_stages_p = 2,
    localparam int unsigned sel_width_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     en_i,
    input  logic                     clear_i,
    input  logic [sel_width_lp-1:0]  sel_i,
    input  logic [num_chan_p-1:0]    sig_i,
    output logic                     v_o,
    input  logic                     ready_i,
    output logic [count_width_p-1:0] data_o,
    output logic                     overflow_o
`ifdef BSG_CHIP_PERIOD_METER_MINMAX_EN
   ,output logic [count_width_p-1:0] min_o
   ,output logic [count_width_p-1:0] max_o
`endif
);

    localparam int unsigned acc_width_lp  = count_width_p + lg_periods_p;
    localparam int unsigned pcnt_width_lp = lg_periods_p + 1;
    localparam int unsigned periods_lp    = 1 << lg_periods_p;

    typedef enum logic [1:0] {e_idle, e_arm, e_count, e_done} state_e;

    state_e state_r, state_n;

    logic [sync_stages_p-1:0][num_chan_p-1:0] sync_r;
    logic [num_chan_p-1:0]    prev_r;
    logic [num_chan_p-1:0]    rise;
    logic [sel_width_lp-1:0]  sel_r, sel_n, sel_clamped;
    logic                     rise_sel;

    logic [acc_width_lp-1:0]  acc_r, acc_n, acc_inc;
    logic                     acc_sat;
    logic [pcnt_width_lp-1:0] pcnt_r, pcnt_n, pcnt_inc;
    logic                     pcnt_done;
    logic                     done_entry;

    logic                     v_n;
    logic [count_width_p-1:0] data_n;
    logic                     ovf_n;

    // Synchroniser chain plus one edge flop per input bit.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_r <= '0;
            prev_r <= '0;
        end else begin
            sync_r <= {sync_r[sync_stages_p-2:0], sig_i};
            prev_r <= sync_r[sync_stages_p-1];
        end
    end

    assign rise = sync_r[sync_stages_p-1] & ~prev_r;

    // Out-of-range select falls back to channel 0.
    always_comb begin
        sel_clamped = '0;
        if (32'(sel_i) < num_chan_p) sel_clamped = sel_i;
    end

    // Rise detect of the latched channel.
    always_comb begin
        rise_sel = 1'b0;
        for (int i = 0; i < int'(num_chan_p); i++) begin
            if (sel_r == sel_width_lp'(i)) rise_sel = rise[i];
        end
    end

    // Saturating accumulator increment and period-count terminal test.
    always_comb begin
        acc_inc   = (&acc_r) ? acc_r : acc_r + acc_width_lp'(1);
        acc_sat   = &acc_inc;
        pcnt_inc  = pcnt_r + pcnt_width_lp'(1);
        pcnt_done = (pcnt_inc == pcnt_width_lp'(periods_lp));
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= e_idle;
        else         state_r <= state_n;
    end

    // Next-state logic: clear beats en abort beats normal progress.
    always_comb begin
        state_n = state_r;
        if (clear_i) begin
            state_n = e_idle;
        end else begin
            case (state_r)
                e_idle:  if (en_i) state_n = e_arm;
                e_arm: begin
                    if (!en_i)         state_n = e_idle;
                    else if (acc_sat)  state_n = e_done;
                    else if (rise_sel) state_n = e_count;
                end
                e_count: begin
                    if (!en_i)                       state_n = e_idle;
                    else if (acc_sat)                state_n = e_done;
                    else if (rise_sel && pcnt_done)  state_n = e_done;
                end
                e_done:  if (v_o && ready_i) state_n = e_idle;
                default: state_n = e_idle;
            endcase
        end
    end

    // Datapath and result next values; results load only on DONE entry.
    always_comb begin
        acc_n      = acc_r;
        pcnt_n     = pcnt_r;
        sel_n      = sel_r;
        v_n        = (state_n == e_done);
        done_entry = (state_r != e_done) && (state_n == e_done);
        data_n     = data_o;
        ovf_n      = overflow_o;
        case (state_r)
            e_idle: begin
                acc_n  = '0;
                pcnt_n = '0;
                if (state_n == e_arm) sel_n = sel_clamped;
            end
            e_arm: begin
                pcnt_n = '0;
                acc_n  = (state_n == e_count) ? '0 : acc_inc;
            end
            e_count: begin
                acc_n = acc_inc;
                if (rise_sel) pcnt_n = pcnt_inc;
            end
            default: ;
        endcase
        if (done_entry) begin
            ovf_n  = acc_sat;
            data_n = acc_sat ? '1 : count_width_p'(acc_inc >> lg_periods_p);
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_r      <= '0;
            pcnt_r     <= '0;
            sel_r      <= '0;
            v_o        <= 1'b0;
            data_o     <= '0;
            overflow_o <= 1'b0;
        end else begin
            acc_r      <= acc_n;
            pcnt_r     <= pcnt_n;
            sel_r      <= sel_n;
            v_o        <= v_n;
            data_o     <= data_n;
            overflow_o <= ovf_n;
        end
    end

`ifdef BSG_CHIP_PERIOD_METER_MINMAX_EN
    logic [count_width_p-1:0] per_r, per_n;
    logic [count_width_p-1:0] min_r, min_n, max_r, max_n;
    logic [count_width_p-1:0] min_upd, max_upd, min_o_n, max_o_n;

    // Per-period counter restarts at 1 after each rise; running min/max.
    always_comb begin
        per_n   = rise_sel ? count_width_p'(1)
                           : ((&per_r) ? per_r : per_r + count_width_p'(1));
        min_upd = (per_r < min_r) ? per_r : min_r;
        max_upd = (per_r > max_r) ? per_r : max_r;
        min_n   = min_r;
        max_n   = max_r;
        if (state_r == e_arm && state_n == e_count) begin
            min_n = '1;
            max_n = '0;
        end else if (state_r == e_count && rise_sel) begin
            min_n = min_upd;
            max_n = max_upd;
        end
        min_o_n = min_o;
        max_o_n = max_o;
        if (done_entry) begin
            min_o_n = acc_sat ? '1 : min_upd;
            max_o_n = acc_sat ? '1 : max_upd;
        end
    end

    // Min/max registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            per_r <= '0;
            min_r <= '0;
            max_r <= '0;
            min_o <= '0;
            max_o <= '0;
        end else begin
            per_r <= per_n;
            min_r <= min_n;
            max_r <= max_n;
            min_o <= min_o_n;
            max_o <= max_o_n;
        end
    end
`endif

endmodule

// File: tb/tb_bsg_chip_period_meter.sv
// tb_bsg_chip_period_meter: scoreboard bench for the period meter
// (num_chan_p=2, count_width_p=8, lg_periods_p=2).
module tb_bsg_chip_period_meter;

    logic       clk_i = 1'b0;
    logic       reset_i, en_i, clear_i, sel_i, ready_i;
    logic       v_o, overflow_o;
    logic [1:0] sig_i;
    logic [7:0] data_o;
    logic       sig0, sig1;
`ifdef BSG_CHIP_PERIOD_METER_MINMAX_EN
    logic [7:0] min_o, max_o;
`endif

    assign sig_i = {sig1, sig0};

    bsg_chip_period_meter #(
        .num_chan_p(2), .count_width_p(8), .lg_periods_p(2), .sync_stages_p(2)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .clear_i(clear_i),
        .sel_i(sel_i), .sig_i(sig_i), .v_o(v_o), .ready_i(ready_i),
        .data_o(data_o), .overflow_o(overflow_o)
`ifdef BSG_CHIP_PERIOD_METER_MINMAX_EN
       ,.min_o(min_o), .max_o(max_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
        logic [7:0] mn;
        logic [7:0] mx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   results_seen = 0;
    int   last_rise_cyc = 0;
    int   prev_rise_cyc = 0;
    logic v_prev = 1'b0;
    logic [7:0] held_data;
    logic       held_ovf;

    int per0_a = 14, per0_b = 14, per1_a = 10, per1_b = 10;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic o, input logic [7:0] mn, input logic [7:0] mx);
        exp_t e;
        e.data = d; e.ovf = o; e.mn = mn; e.mx = mx;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wait_results(input int n, input int budget);
        int target;
        int k;
        target = results_seen + n;
        k = 0;
        while (results_seen < target && k < budget) begin
            step(1);
            k++;
        end
        check("result_arrived", 32'(results_seen >= target), 1);
    endtask

    // Channel 0 source: alternating periods per0_a / per0_b (<2 holds low).
    initial begin : gen_ch0
        int p;
        bit ph;
        sig0 = 1'b0;
        ph = 1'b0;
        forever begin
            p = ph ? per0_b : per0_a;
            ph = ~ph;
            if (p < 2) begin
                @(posedge clk_i); #1 sig0 = 1'b0;
            end else begin
                @(posedge clk_i); #1 sig0 = 1'b1;
                repeat (p / 2) @(posedge clk_i);
                #1 sig0 = 1'b0;
                repeat (p - p / 2 - 1) @(posedge clk_i);
            end
        end
    end

    // Channel 1 source.
    initial begin : gen_ch1
        int p;
        bit ph;
        sig1 = 1'b0;
        ph = 1'b0;
        forever begin
            p = ph ? per1_b : per1_a;
            ph = ~ph;
            if (p < 2) begin
                @(posedge clk_i); #1 sig1 = 1'b0;
            end else begin
                @(posedge clk_i); #1 sig1 = 1'b1;
                repeat (p / 2) @(posedge clk_i);
                #1 sig1 = 1'b0;
                repeat (p - p / 2 - 1) @(posedge clk_i);
            end
        end
    end

    // Monitor: pop expectation on each new result, then check it stays stable.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (v_o && !v_prev) begin
                results_seen++;
                prev_rise_cyc = last_rise_cyc;
                last_rise_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", 32'(data_o), 32'(e.data));
                    check("overflow", 32'(overflow_o), 32'(e.ovf));
`ifdef BSG_CHIP_PERIOD_METER_MINMAX_EN
                    check("min", 32'(min_o), 32'(e.mn));
                    check("max", 32'(max_o), 32'(e.mx));
`endif
                end
                held_data = data_o;
                held_ovf  = overflow_o;
            end else if (v_o) begin
                check("hold_data", 32'(data_o), 32'(held_data));
                check("hold_ovf", 32'(overflow_o), 32'(held_ovf));
            end
            v_prev = v_o;
        end
    end

    initial begin : main
        int t0;
        reset_i = 1'b1; en_i = 1'b0; clear_i = 1'b0; sel_i = 1'b0; ready_i = 1'b1;
        step(4);
        check("rst_v", 32'(v_o), 0);
        check("rst_data", 32'(data_o), 0);
        check("rst_ovf", 32'(overflow_o), 0);
        reset_i = 1'b0;
        step(2);

        // Continuous mode on channel 1, period 10.
        sel_i = 1'b1;
        push_exp(8'd10, 1'b0, 8'd10, 8'd10);
        push_exp(8'd10, 1'b0, 8'd10, 8'd10);
        en_i = 1'b1;
        wait_results(2, 300);
        en_i = 1'b0;
        check("cont_gap_ok", 32'((last_rise_cyc - prev_rise_cyc) >= 40 &&
                                 (last_rise_cyc - prev_rise_cyc) <= 50), 1);
        step(5);

        // Channel 0 alternating 9/11.
        per0_a = 9; per0_b = 11;
        step(30);
        sel_i = 1'b0;
        push_exp(8'd10, 1'b0, 8'd9, 8'd11);
        en_i = 1'b1;
        wait_results(1, 200);
        en_i = 1'b0;
        per0_a = 14; per0_b = 14;
        step(5);

        // No signal: ARM timeout.
        per1_a = 0; per1_b = 0;
        step(25);
        sel_i = 1'b1;
        push_exp(8'd255, 1'b1, 8'd255, 8'd255);
        t0 = cyc;
        en_i = 1'b1;
        wait_results(1, 1200);
        en_i = 1'b0;
        check("timeout_latency_ok", 32'((last_rise_cyc - t0) >= 1023 &&
                                        (last_rise_cyc - t0) <= 1025), 1);
        step(3);

        // Period 300: accumulator saturates in COUNT.
        per1_a = 300; per1_b = 300;
        step(2);
        push_exp(8'd255, 1'b1, 8'd255, 8'd255);
        en_i = 1'b1;
        wait_results(1, 1600);
        en_i = 1'b0;
        per1_a = 10; per1_b = 10;
        step(320);

        // Hold under ready_i=0 with en/sel wiggling; sel change mid-COUNT.
        ready_i = 1'b0;
        sel_i = 1'b1;
        push_exp(8'd10, 1'b0, 8'd10, 8'd10);
        en_i = 1'b1;
        step(20);
        sel_i = 1'b0;
        wait_results(1, 200);
        for (int i = 0; i < 50; i++) begin
            en_i  = i[0];
            sel_i = i[1];
            step(1);
        end
        check("hold_v", 32'(v_o), 1);
        en_i = 1'b0; sel_i = 1'b1; ready_i = 1'b1;
        step(1);
        check("accept_v_drop", 32'(v_o), 0);
        step(3);

        // Clear mid-COUNT: aborted result never appears, restart is correct.
        en_i = 1'b1;
        step(20);
        clear_i = 1'b1;
        t0 = cyc;
        step(1);
        clear_i = 1'b0;
        check("clr_count_v", 32'(v_o), 0);
        push_exp(8'd10, 1'b0, 8'd10, 8'd10);
        wait_results(1, 200);
        en_i = 1'b0;
        check("clr_restart_ok", 32'((last_rise_cyc - t0) >= 40), 1);
        step(3);

        // Clear in DONE while ready_i=0.
        ready_i = 1'b0;
        push_exp(8'd10, 1'b0, 8'd10, 8'd10);
        en_i = 1'b1;
        wait_results(1, 200);
        en_i = 1'b0;
        step(3);
        check("done_before_clr_v", 32'(v_o), 1);
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        check("clr_done_v", 32'(v_o), 0);
        step(60);
        check("clr_done_quiet", 32'(v_o), 0);
        ready_i = 1'b1;
        push_exp(8'd10, 1'b0, 8'd10, 8'd10);
        en_i = 1'b1;
        wait_results(1, 200);
        en_i = 1'b0;
        step(3);

        // Reset while in DONE.
        ready_i = 1'b0;
        push_exp(8'd10, 1'b0, 8'd10, 8'd10);
        en_i = 1'b1;
        wait_results(1, 200);
        step(2);
        reset_i = 1'b1;
        step(1);
        check("rst_done_v", 32'(v_o), 0);
        check("rst_done_data", 32'(data_o), 0);
        check("rst_done_ovf", 32'(overflow_o), 0);
        reset_i = 1'b0;
        ready_i = 1'b1;
        push_exp(8'd10, 1'b0, 8'd10, 8'd10);
        wait_results(1, 200);
        en_i = 1'b0;
        step(3);

        // Reset while in COUNT.
        en_i = 1'b1;
        step(20);
        reset_i = 1'b1;
        step(1);
        check("rst_count_v", 32'(v_o), 0);
        check("rst_count_data", 32'(data_o), 0);
        check("rst_count_ovf", 32'(overflow_o), 0);
        reset_i = 1'b0;
        push_exp(8'd10, 1'b0, 8'd10, 8'd10);
        wait_results(1, 200);
        en_i = 1'b0;
        step(5);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
